// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU load/store path.
// Accepts one request at a time, services it against an internal word RAM
// with WAIT_STATES extra cycles after the array read, performs sub-word
// stores as read-modify-write and answers with a one-cycle response pulse.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-low reset
//   req_valid/req_ready     - request handshake (ready only in IDLE)
//   req_write/size/addr/wdata - request fields, captured on accept
//   resp_valid              - one-cycle response pulse
//   resp_rdata/resp_err     - registered response data / error flag

// Byte-lane merge: picks the new store byte when the lane is enabled.
module mem_byte_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       en,
  output logic [7:0] merged
);
  assign merged = en ? new_byte : old_byte;
endmodule

module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [1:0] SZ_WORD   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_BYTE   = 2'b10;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  state_t                  state, state_n;
  logic                    accept, req_err;
  logic                    cap_write;
  logic [1:0]              cap_size, cap_off;
  logic [ADDR_WIDTH-1:0]   cap_idx;
  logic [31:0]             cap_wdata, buf_q, mem_rd, rd_word, rd_shift, load_data;
  logic [31:0]             wdata_rep, merged;
  logic [NUM_LANES-1:0]    lane_en;
  logic [3:0]              wait_cnt;
  logic [31:0]             mem [2**ADDR_WIDTH];

  // Upper address bits alias onto the array and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign accept = req_valid & req_ready;

  always_comb begin
    unique case (req_size)
      SZ_WORD: req_err = |req_addr[1:0];
      SZ_HALF: req_err = req_addr[0];
      SZ_BYTE: req_err = 1'b0;
      default: req_err = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state / outputs. req_ready is gated by reset so it reads 0
  // for the whole reset assertion, whatever state is still registered.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = reset;
        if (req_valid && reset) state_n = req_err ? RESP : READ;
      end
      READ: begin
        if (WAIT_STATES > 0) state_n = WAIT;
        else                 state_n = cap_write ? WRITE : RESP;
      end
      WAIT:  if (wait_cnt == 4'd1) state_n = cap_write ? WRITE : RESP;
      WRITE: state_n = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Asynchronous array read; in READ the buffer is not loaded yet, so a
  // zero-wait load takes its data straight from the array.
  assign mem_rd  = mem[cap_idx];
  assign rd_word = (state == READ) ? mem_rd : buf_q;

  always_comb begin
    rd_shift  = rd_word >> {cap_off, 3'b000};
    load_data = rd_word;
    unique case (cap_size)
      SZ_HALF: load_data = {16'd0, rd_word[16*cap_off[1] +: 16]};
      SZ_BYTE: load_data = {24'd0, rd_shift[7:0]};
      default: load_data = rd_word;
    endcase
  end

  // Store data replicated across lanes; the lane enables choose which land.
  always_comb begin
    unique case (cap_size)
      SZ_WORD: begin wdata_rep = cap_wdata;              lane_en = 4'b1111; end
      SZ_HALF: begin wdata_rep = {2{cap_wdata[15:0]}};
                     lane_en   = cap_off[1] ? 4'b1100 : 4'b0011; end
      SZ_BYTE: begin wdata_rep = {4{cap_wdata[7:0]}};    lane_en = 4'b0001 << cap_off; end
      default: begin wdata_rep = cap_wdata;              lane_en = 4'b0000; end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_byte_lane u_lane (
      .old_byte (buf_q[8*i +: 8]),
      .new_byte (wdata_rep[8*i +: 8]),
      .en       (lane_en[i]),
      .merged   (merged[8*i +: 8])
    );
  end

  // Datapath: request capture, read buffer, wait counter, response regs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt   <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_size  <= req_size;
        cap_off   <= req_addr[1:0];
        cap_idx   <= req_addr[ADDR_WIDTH+1:2];
        cap_wdata <= req_wdata;
      end
      unique case (state)
        READ: begin
          buf_q <= mem_rd;
          if (WAIT_STATES > 0) wait_cnt <= WAIT_INIT;
        end
        WAIT:    wait_cnt <= wait_cnt - 4'd1;
        default: ;
      endcase
      if (accept && req_err) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b1;
      end else if (state_n == RESP && !cap_write && (state == READ || state == WAIT)) begin
        resp_rdata <= load_data;
        resp_err   <= 1'b0;
      end else if (state == WRITE) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Array write at the end of WRITE; reset in that cycle suppresses it.
  always_ff @(posedge clock) begin
    if (reset && state == WRITE) mem[cap_idx] <= merged;
  end
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  logic        clock = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   asserts = 0;
  int   fails   = 0;
  int   ecnt    = 0;

  always #5 clock = ~clock;
  always @(posedge clock) ecnt <= ecnt + 1;

  mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3)) dut3 (
    .clock(clock), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_resp(input int d, input exp_t e);
    cmp($sformatf("dut%0d rdata", d), resp_rdata[d], e.rdata);
    cmp($sformatf("dut%0d err", d), {31'd0, resp_err[d]}, {31'd0, e.err});
    cmp($sformatf("dut%0d resp cycle", d), ecnt, e.cyc);
  endtask

  // Monitors: pop the oldest expectation on every response pulse.
  always @(negedge clock) begin
    if (resp_valid[0]) begin
      if (q0.size() == 0) cmp("dut0 unexpected response", 32'd1, 32'd0);
      else check_resp(0, q0.pop_front());
    end
  end

  always @(negedge clock) begin
    if (resp_valid[1]) begin
      if (q1.size() == 0) cmp("dut1 unexpected response", 32'd1, 32'd0);
      else check_resp(1, q1.pop_front());
    end
  end

  // Called at a negedge. Waits (bounded) for ready, optionally pulsing
  // req_valid with a bogus store while busy, then issues one request and
  // pushes its expected response; returns at the negedge of cycle 1.
  task automatic issue(input int d, input bit wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input bit exp_err,
                       input int lat, input bit pulse);
    exp_t e;
    int   k = 0;
    while (!req_ready[d] && k < 100) begin
      req_valid[d] = pulse & k[0];
      req_write[d] = 1'b1;
      req_size[d]  = 2'b00;
      req_addr[d]  = 32'h0;
      k++;
      @(negedge clock);
    end
    req_valid[d] = 1'b0;
    if (!req_ready[d]) begin
      cmp($sformatf("dut%0d ready timeout", d), 32'd0, 32'd1);
      return;
    end
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_size[d]  = sz;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.cyc   = ecnt + lat;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clock);
    req_valid[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_size[d] = 2'b00; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      cmp($sformatf("dut%0d reset ready", d), {31'd0, req_ready[d]}, 32'd0);
      cmp($sformatf("dut%0d reset valid", d), {31'd0, resp_valid[d]}, 32'd0);
      cmp($sformatf("dut%0d reset rdata", d), resp_rdata[d], 32'd0);
      cmp($sformatf("dut%0d reset err", d), {31'd0, resp_err[d]}, 32'd0);
    end
    rst[0] = 1'b1; rst[1] = 1'b1;
    #1;
    cmp("dut0 ready after release", {31'd0, req_ready[0]}, 32'd1);
    cmp("dut1 ready after release", {31'd0, req_ready[1]}, 32'd1);
    @(negedge clock);

    // ---- WAIT_STATES = 0: store 3 cycles, load 2, error 1 ----
    issue(0, 1, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0,        0, 3, 0);
    issue(0, 0, 2'b00, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0);
    issue(0, 1, 2'b10, 32'h11, 32'h555555AA, 32'h0,        0, 3, 0);
    issue(0, 0, 2'b00, 32'h10, 32'h0,        32'hDEADAAEF, 0, 2, 0);
    issue(0, 0, 2'b10, 32'h13, 32'h0,        32'h000000DE, 0, 2, 0);
    issue(0, 1, 2'b01, 32'h12, 32'hABCD1234, 32'h0,        0, 3, 0);
    issue(0, 0, 2'b00, 32'h10, 32'h0,        32'h1234AAEF, 0, 2, 0);
    issue(0, 0, 2'b01, 32'h10, 32'h0,        32'h0000AAEF, 0, 2, 0);
    issue(0, 0, 2'b01, 32'h12, 32'h0,        32'h00001234, 0, 2, 0);
    issue(0, 0, 2'b10, 32'h12, 32'h0,        32'h00000034, 0, 2, 0);
    issue(0, 1, 2'b00, 32'h00, 32'hCAFEF00D, 32'h0,        0, 3, 0);
    issue(0, 0, 2'b01, 32'h11, 32'h0,        32'h0,        1, 1, 0);
    issue(0, 1, 2'b00, 32'h02, 32'hFFFFFFFF, 32'h0,        1, 1, 0);
    issue(0, 0, 2'b11, 32'h00, 32'h0,        32'h0,        1, 1, 0);
    issue(0, 1, 2'b11, 32'h10, 32'hFFFFFFFF, 32'h0,        1, 1, 0);
    issue(0, 0, 2'b00, 32'h00, 32'h0,        32'hCAFEF00D, 0, 2, 0);
    issue(0, 0, 2'b00, 32'h10, 32'h0,        32'h1234AAEF, 0, 2, 0);

    // ---- reset during the WRITE cycle of a store ----
    issue(0, 1, 2'b00, 32'h20, 32'h55667788, 32'h0,        0, 3, 0);
    issue(0, 0, 2'b00, 32'h20, 32'h0,        32'h55667788, 0, 2, 0);
    begin
      int k = 0;
      while (!req_ready[0] && k < 20) begin k++; @(negedge clock); end
      cmp("dut0 ready before aborted store", {31'd0, req_ready[0]}, 32'd1);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_size[0] = 2'b00;
      req_addr[0] = 32'h20; req_wdata[0] = 32'h11111111;
      @(negedge clock);              // cycle 1: READ
      req_valid[0] = 1'b0;
      @(negedge clock);              // cycle 2: WRITE
      rst[0] = 1'b0;
      @(negedge clock);
      cmp("abort ready low in reset", {31'd0, req_ready[0]}, 32'd0);
      cmp("abort no resp_valid", {31'd0, resp_valid[0]}, 32'd0);
      cmp("abort rdata cleared", resp_rdata[0], 32'd0);
      cmp("abort err cleared", {31'd0, resp_err[0]}, 32'd0);
      rst[0] = 1'b1;
      #1;
      cmp("abort ready after release", {31'd0, req_ready[0]}, 32'd1);
      @(negedge clock);
    end
    issue(0, 0, 2'b00, 32'h420, 32'h0,       32'h55667788, 0, 2, 0);
    issue(0, 0, 2'b00, 32'h20,  32'h0,       32'h55667788, 0, 2, 0);

    // ---- WAIT_STATES = 3: load 5 cycles, store 6, busy pulses ignored ----
    issue(1, 1, 2'b00, 32'h40, 32'h0BADF00D, 32'h0,        0, 6, 1);
    issue(1, 0, 2'b00, 32'h40, 32'h0,        32'h0BADF00D, 0, 5, 1);
    issue(1, 0, 2'b10, 32'h41, 32'h0,        32'h000000F0, 0, 5, 1);
    issue(1, 1, 2'b01, 32'h42, 32'h00005A5A, 32'h0,        0, 6, 1);
    issue(1, 0, 2'b00, 32'h40, 32'h0,        32'h5A5AF00D, 0, 5, 1);
    issue(1, 1, 2'b00, 32'h41, 32'h12345678, 32'h0,        1, 1, 1);
    issue(1, 0, 2'b01, 32'h42, 32'h0,        32'h00005A5A, 0, 5, 1);

    repeat (20) @(negedge clock);
    cmp("dut0 all responses seen", q0.size(), 32'd0);
    cmp("dut1 all responses seen", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU's load/store path. It accepts one request at a time from the CPU datapath, and services it against an internal word-organised RAM with a configurable number of wait states. Sub-word stores are performed as read-modify-write. It answers with a single-cycle response pulse carrying lane-extracted read data or an alignment error.

## Interface
- ADDR_WIDTH, 8, word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 0, extra cycles inserted after the array read. Legal range is 0..15.

Ports:
- clock  in  1  system clock; everything is updated on the rising edge.
- reset  in  1  reset, synchronous and active-low.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 halfword, 10 byte, 11 reserved.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data, zero-extended and right-justified; 0 for stores and errors.
- resp_err  out  1  request rejected; qualified by resp_valid.

## Operation
- Word index is req_addr[ADDR_WIDTH+1:2]. Address bits above the index are ignored, so the array aliases.
- Byte lanes are little-endian: the byte at addr[1:0]=0 is bits [7:0]; the half at addr[1]=1 is bits [31:16].
- Error conditions:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0.
- On error: no array access, no write, resp_err=1, resp_rdata=0.
- All request fields are captured in internal registers on the accept edge (req_valid & req_ready). Inputs are don't-care after that edge.
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
  - IDLE: req_ready=1. On accept, go to RESP if the request is an error, otherwise to READ.
  - READ: the array word at the captured index is latched into an internal buffer. Next state is WAIT if WAIT_STATES>0, else WRITE for a store, else RESP.
  - WAIT: a counter loads WAIT_STATES on entry and decrements each cycle. On the cycle it reads 1, exit to WRITE (store) or RESP (load).
  - WRITE: the captured store lanes are merged into the buffered word, and the merged word is written to the array at the end of the cycle. Word stores also take this path. Next state is RESP.
  - RESP: resp_valid=1 for exactly this cycle, then IDLE.
- Load data:
  - byte: buffer[8*addr[1:0] +: 8] zero-extended.
  - half: buffer[16*addr[1] +: 16] zero-extended.
  - word: the whole buffer.
- resp_rdata and resp_err are registered. They hold their value until the next RESP.
- There is no response backpressure; the CPU must sample resp_* in the RESP cycle.
- Reset:
  - Synchronous active-low reset has priority over all other activity.
  - Reset state: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - req_ready=0 while reset is low and 1 in the first cycle after release.
  - Array contents are not reset.
- Reset mid-operation aborts the transaction with no response. A store reset while in WRITE must leave the array unmodified.

## Timing
- Cycle 0 is the accept edge.
- Load: resp_valid is high in cycle 2+WAIT_STATES.
- Store: resp_valid is high in cycle 3+WAIT_STATES. The array is updated at the end of cycle 2+WAIT_STATES, so a load accepted immediately after the store response sees the new data.
- Error: resp_valid is high in cycle 1.
- Back-to-back operation: req_ready rises in the cycle after RESP. The minimum request spacing is therefore 3+W cycles for loads, 4+W for stores and 2 for errors.
- req_valid while req_ready=0 is ignored; the request is not queued.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 (WAIT_STATES=0) -> store resp_valid in cycle 3 with resp_err=0; load resp_valid in cycle 2 with resp_rdata=0xDEADBEEF.
- Store byte 0xAA at 0x11, then load word at 0x10 -> 0xDEADAAEF. Load byte at 0x13 -> 0x000000DE.
- Store half 0x1234 at 0x12, then load word at 0x10 -> 0x1234AAEF. Load half at 0x10 -> 0x0000AAEF.
- Load half at 0x11, store word at 0x02, and any request with size 11 -> resp_valid in cycle 1, resp_err=1, resp_rdata=0. A following word load at 0x00/0x10 shows unchanged contents.
- WAIT_STATES=3: load -> resp_valid in cycle 5; store -> resp_valid in cycle 6. req_valid pulses while busy are ignored, with exactly one response per accepted request.
- Store 0x11111111 at 0x20 with reset driven low during WRITE -> no resp_valid; req_ready=1 after release. A subsequent load at 0x20 returns the pre-store value. Address 0x20+(4<<ADDR_WIDTH) aliases to the same word.
